// File: rtl/matrix_pkg.sv
// ============================================================================
// Module   : matrix_pkg
// Purpose  : Shared types and default dimensions for the matrix datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

package matrix_pkg;

   localparam int DEF_ROWS  = 3;
   localparam int DEF_COLS  = 3;
   localparam int DEF_WIDTH = 32;

   typedef enum logic [1:0] {
      LOAD_A    = 2'd0,
      LOAD_B    = 2'd1,
      START     = 2'd2,
      WAIT_DONE = 2'd3
   } loader_state_t;

   // Index width for a dimension of n entries; a 1-entry dimension still needs one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_elem_counter.sv
// ============================================================================
// Module   : matrix_elem_counter
// Purpose  : Row-major row/column index counter with a last-element flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module matrix_elem_counter
   import matrix_pkg::*;
#(
   parameter  int ROWS = DEF_ROWS,
   parameter  int COLS = DEF_COLS,
   localparam int RW   = cnt_width(ROWS),
   localparam int CW   = cnt_width(COLS)
) (
   input  logic          clock,
   input  logic          nreset,
   input  logic          inc,
   input  logic          clr,
   output logic [RW-1:0] row,
   output logic [CW-1:0] col,
   output logic          last
);

   localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
   localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

   assign last = (row == ROW_MAX) && (col == COL_MAX);

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         row <= '0;
         col <= '0;
      end else if (clr) begin
         row <= '0;
         col <= '0;
      end else if (inc) begin
         if (col == COL_MAX) begin
            col <= '0;
            row <= (row == ROW_MAX) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/matrix_operand_loader.sv
// ============================================================================
// Module   : matrix_operand_loader
// Purpose  : Streams A then B (row-major) into operand arrays, pulses start,
//            and holds operands until the multiplier reports completion.
// Revision : 1.0
// ============================================================================
`default_nettype none

module matrix_operand_loader
   import matrix_pkg::*;
#(
   parameter int AROWS     = DEF_ROWS,
   parameter int ACOLUMNS  = DEF_COLS,
   parameter int BROWS     = DEF_ROWS,
   parameter int BCOLUMNS  = DEF_COLS,
   parameter int WIDTH_BIT = DEF_WIDTH
) (
   input  logic                 clock,
   input  logic                 nreset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH_BIT-1:0] in_data,
   input  logic                 in_last,
   output logic [WIDTH_BIT-1:0] MatrixA [AROWS-1:0][ACOLUMNS-1:0],
   output logic [WIDTH_BIT-1:0] MatrixB [BROWS-1:0][BCOLUMNS-1:0],
   output logic                 start,
   input  logic                 mult_done,
   output logic                 frame_err
);

   localparam int ARW = cnt_width(AROWS);
   localparam int ACW = cnt_width(ACOLUMNS);
   localparam int BRW = cnt_width(BROWS);
   localparam int BCW = cnt_width(BCOLUMNS);

   if (ACOLUMNS != BROWS) begin : g_dim_check
      $error("matrix_operand_loader: ACOLUMNS (%0d) must equal BROWS (%0d)", ACOLUMNS, BROWS);
   end

   loader_state_t state;

   logic           xfer;
   logic           a_inc, a_clr, a_last, a_done;
   logic           b_inc, b_clr, b_last;
   logic           frame_ok, frame_bad;
   logic [ARW-1:0] a_row;
   logic [ACW-1:0] a_col;
   logic [BRW-1:0] b_row;
   logic [BCW-1:0] b_col;

   assign in_ready = (state == LOAD_A) || (state == LOAD_B);
   assign xfer     = in_valid && in_ready;

   matrix_elem_counter #(.ROWS(AROWS), .COLS(ACOLUMNS)) u_cnt_a (
      .clock (clock),
      .nreset(nreset),
      .inc   (a_inc),
      .clr   (a_clr),
      .row   (a_row),
      .col   (a_col),
      .last  (a_last)
   );

   matrix_elem_counter #(.ROWS(BROWS), .COLS(BCOLUMNS)) u_cnt_b (
      .clock (clock),
      .nreset(nreset),
      .inc   (b_inc),
      .clr   (b_clr),
      .row   (b_row),
      .col   (b_col),
      .last  (b_last)
   );

   // Any end of frame, good or bad, rewinds both counters to element 0.
   always_comb begin
      a_inc     = 1'b0;
      a_clr     = 1'b0;
      a_done    = 1'b0;
      b_inc     = 1'b0;
      b_clr     = 1'b0;
      frame_ok  = 1'b0;
      frame_bad = 1'b0;
      if (xfer) begin
         case (state)
            LOAD_A: begin
               if (in_last)     frame_bad = 1'b1;
               else if (a_last) begin
                  a_clr  = 1'b1;
                  a_done = 1'b1;
               end
               else             a_inc = 1'b1;
            end
            LOAD_B: begin
               if (b_last) begin
                  frame_ok  = in_last;
                  frame_bad = !in_last;
               end
               else if (in_last) frame_bad = 1'b1;
               else              b_inc = 1'b1;
            end
            default: ;
         endcase
      end
      if (frame_ok || frame_bad) begin
         a_clr = 1'b1;
         b_clr = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state     <= LOAD_A;
         start     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         start     <= 1'b0;
         frame_err <= frame_bad;
         case (state)
            LOAD_A:    if (a_done) state <= LOAD_B;
            LOAD_B: begin
               if (frame_ok) begin
                  state <= START;
                  start <= 1'b1;
               end else if (frame_bad) begin
                  state <= LOAD_A;
               end
            end
            START:     state <= WAIT_DONE;
            WAIT_DONE: if (mult_done) state <= LOAD_A;
            default:   state <= LOAD_A;
         endcase
      end
   end

   // Writes only happen on transfers, so operands are frozen outside LOAD_A/LOAD_B.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         for (int r = 0; r < AROWS; r++)
            for (int c = 0; c < ACOLUMNS; c++)
               MatrixA[r][c] <= '0;
         for (int r = 0; r < BROWS; r++)
            for (int c = 0; c < BCOLUMNS; c++)
               MatrixB[r][c] <= '0;
      end else if (xfer) begin
         if (state == LOAD_A) MatrixA[a_row][a_col] <= in_data;
         else                 MatrixB[b_row][b_col] <= in_data;
      end
   end

endmodule

`default_nettype wire
